// File: rtl/vga_pkg.sv
// SVGA 800x600 timing constants shared by the Sobel receiver and the grayscale transmitter.
// Latency: n/a (constants, types and a width helper only).
// Backpressure: n/a.
package vga_pkg;

    // Horizontal timing in pixel clocks, listed in scan order: sync, back porch, active, front porch.
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BP     = 88;
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 40;
    localparam int SVGA_H_TOTAL  = SVGA_H_SYNC + SVGA_H_BP + SVGA_H_ACTIVE + SVGA_H_FP;

    // Vertical timing in lines, same region order as horizontal.
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BP     = 23;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 1;
    localparam int SVGA_V_TOTAL  = SVGA_V_SYNC + SVGA_V_BP + SVGA_V_ACTIVE + SVGA_V_FP;

    // First counter value of the active region on each axis.
    localparam int SVGA_H_ACT_START = SVGA_H_SYNC + SVGA_H_BP;
    localparam int SVGA_V_ACT_START = SVGA_V_SYNC + SVGA_V_BP;

    // Default image geometry and pixel width of the grayscale stream.
    localparam int DEF_IMG_COLS  = 512;
    localparam int DEF_IMG_ROWS  = 512;
    localparam int DEF_BIT_DEPTH = 8;

    // Per-cycle region decode produced by the sync counter.
    typedef struct packed {
        logic hs_n;         // low during horizontal sync
        logic vs_n;         // low during vertical sync lines
        logic active;       // inside the visible area on both axes
        logic frame_first;  // counters sit at (0,0)
    } sync_flags_t;

    // Counter width able to hold 0..total-1; never narrower than one bit.
    function automatic int cnt_width(input int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Free-running h/v raster counters with region decode (sync, active, active-relative x/y).
// Latency: decode is combinational from the counter registers; counters advance every clock.
// Backpressure: none, timing is absolute and never stalls.
//
// Ports: clk, reset (sync, active-high) | ax/ay: position relative to active-area origin,
//        only meaningful while flags.active | flags: hs_n, vs_n, active, frame_first.
module vga_sync_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = SVGA_H_ACTIVE,
    parameter int H_FP     = SVGA_H_FP,
    parameter int H_SYNC   = SVGA_H_SYNC,
    parameter int H_BP     = SVGA_H_BP,
    parameter int V_ACTIVE = SVGA_V_ACTIVE,
    parameter int V_FP     = SVGA_V_FP,
    parameter int V_SYNC   = SVGA_V_SYNC,
    parameter int V_BP     = SVGA_V_BP,
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP,
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP,
    localparam int HW      = cnt_width(H_TOTAL),
    localparam int VW      = cnt_width(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [HW-1:0] ax,
    output logic [VW-1:0] ay,
    output sync_flags_t   flags
);

    // All region boundaries pre-sized to counter width so every compare is same-width unsigned.
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_BEG  = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_SYNC + H_BP + H_ACTIVE - 1);

    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_BEG  = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(V_SYNC + V_BP + V_ACTIVE - 1);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap;
    logic          h_in_act;
    logic          v_in_act;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    // v_cnt only moves on the h wrap, so the end-of-frame case returns both to zero together.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Inclusive last-index bounds avoid overflow when a front porch of zero puts the
    // active end exactly at the counter's range limit.
    assign h_in_act = (h_cnt >= H_ACT_BEG) && (h_cnt <= H_ACT_LAST);
    assign v_in_act = (v_cnt >= V_ACT_BEG) && (v_cnt <= V_ACT_LAST);

    // Wraps outside the active region; consumers must qualify with flags.active.
    assign ax = h_cnt - H_ACT_BEG;
    assign ay = v_cnt - V_ACT_BEG;

    always_comb begin
        flags             = '0;
        flags.hs_n        = !(h_cnt < H_SYNC_END);
        flags.vs_n        = !(v_cnt < V_SYNC_END);
        flags.active      = h_in_act && v_in_act;
        flags.frame_first = (h_cnt == '0) && (v_cnt == '0);
    end

endmodule

// File: rtl/vga_gray_tx.sv
// SVGA grayscale transmitter: raster timing plus an IMG_COLS x IMG_ROWS image in the top-left.
// Latency: all video outputs registered, one cycle after the counter state they describe.
// Backpressure: pulls pixels with in_valid/in_ready; raster never stalls, a missing pixel
//               is sent as black and latches the sticky underrun flag.
//
// Ports: clk, reset (sync, active-high) | in_pixel/in_valid/in_ready: upstream pixel stream,
//        in_ready combinational | HS, VS: active-low syncs | R, G, B: identical gray level |
//        de: visible area | frame_start: pulse on first cycle of frame | underrun: sticky.
module vga_gray_tx
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = SVGA_H_ACTIVE,
    parameter int H_FP      = SVGA_H_FP,
    parameter int H_SYNC    = SVGA_H_SYNC,
    parameter int H_BP      = SVGA_H_BP,
    parameter int V_ACTIVE  = SVGA_V_ACTIVE,
    parameter int V_FP      = SVGA_V_FP,
    parameter int V_SYNC    = SVGA_V_SYNC,
    parameter int V_BP      = SVGA_V_BP,
    parameter int IMG_COLS  = DEF_IMG_COLS,   // must not exceed H_ACTIVE
    parameter int IMG_ROWS  = DEF_IMG_ROWS,   // must not exceed V_ACTIVE
    parameter int BIT_DEPTH = DEF_BIT_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_DEPTH-1:0] in_pixel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 HS,
    output logic                 VS,
    output logic [BIT_DEPTH-1:0] R,
    output logic [BIT_DEPTH-1:0] G,
    output logic [BIT_DEPTH-1:0] B,
    output logic                 de,
    output logic                 frame_start,
    output logic                 underrun
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW      = cnt_width(H_TOTAL);
    localparam int VW      = cnt_width(V_TOTAL);

    localparam logic [HW-1:0] COLS_W = HW'(IMG_COLS);
    localparam logic [VW-1:0] ROWS_W = VW'(IMG_ROWS);

    logic [HW-1:0]        ax;
    logic [VW-1:0]        ay;
    sync_flags_t          flags;
    logic                 in_window;
    logic                 xfer;
    logic                 starve;
    logic [BIT_DEPTH-1:0] pix;

    vga_sync_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .ax    (ax),
        .ay    (ay),
        .flags (flags)
    );

    // ax/ay are only trusted once flags.active confirms we are inside the visible area.
    assign in_window = flags.active && (ax < COLS_W) && (ay < ROWS_W);

    // Ready is masked by reset so nothing is consumed while the raster is being restarted.
    assign in_ready = in_window && !reset;
    assign xfer     = in_ready && in_valid;
    assign starve   = in_ready && !in_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            HS          <= 1'b1;
            VS          <= 1'b1;
            de          <= 1'b0;
            frame_start <= 1'b0;
            pix         <= '0;
            underrun    <= 1'b0;
        end else begin
            HS          <= flags.hs_n;
            VS          <= flags.vs_n;
            de          <= flags.active;
            frame_start <= flags.frame_first;
            // Porches, sync, area outside the image and starved slots all go out black.
            pix         <= xfer ? in_pixel : '0;
            underrun    <= underrun | starve;
        end
    end

    assign R = pix;
    assign G = pix;
    assign B = pix;

endmodule

// File: tb/tb_vga_gray_tx.sv
module tb_vga_gray_tx;

    // Full SVGA instance geometry
    localparam int BH_TOT  = 1056;
    localparam int BV_TOT  = 628;
    localparam int BH_SYNC = 128;
    localparam int BV_SYNC = 4;
    localparam int BH_ST   = 216;
    localparam int BV_ST   = 27;
    localparam int BH_ACT  = 800;
    localparam int BV_ACT  = 600;
    localparam int BCOLS   = 512;
    localparam int BROWS   = 512;

    // Reduced instance: H 2/2/8/2, V 2/2/2/2, image 4x2
    localparam int SH_TOT  = 14;
    localparam int SV_TOT  = 8;
    localparam int SH_SYNC = 2;
    localparam int SV_SYNC = 2;
    localparam int SH_ST   = 4;
    localparam int SV_ST   = 4;
    localparam int SH_ACT  = 8;
    localparam int SV_ACT  = 2;
    localparam int SCOLS   = 4;
    localparam int SROWS   = 2;
    localparam int SFRAME  = SH_TOT * SV_TOT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       b_reset, b_in_valid, b_in_ready, b_hs, b_vs, b_de, b_fs, b_un;
    logic [7:0] b_in_pixel, b_r, b_g, b_b;
    logic       s_reset, s_in_valid, s_in_ready, s_hs, s_vs, s_de, s_fs, s_un;
    logic [7:0] s_in_pixel, s_r, s_g, s_b;

    int n_checks = 0;
    int n_fail   = 0;
    int bk       = 0;   // big instance: clocks since reset release == current counter state
    int sk       = 0;   // small instance, same meaning

    vga_gray_tx dut_big (
        .clk(clk), .reset(b_reset), .in_pixel(b_in_pixel), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .HS(b_hs), .VS(b_vs), .R(b_r), .G(b_g), .B(b_b),
        .de(b_de), .frame_start(b_fs), .underrun(b_un)
    );

    vga_gray_tx #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(2), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .IMG_COLS(4), .IMG_ROWS(2), .BIT_DEPTH(8)
    ) dut_small (
        .clk(clk), .reset(s_reset), .in_pixel(s_in_pixel), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .HS(s_hs), .VS(s_vs), .R(s_r), .G(s_g), .B(s_b),
        .de(s_de), .frame_start(s_fs), .underrun(s_un)
    );

    // Reference raster model, written from the timing table.
    function automatic bit b_act(int k);
        int h = k % BH_TOT;
        int v = (k / BH_TOT) % BV_TOT;
        return (h >= BH_ST) && (h < BH_ST + BH_ACT) && (v >= BV_ST) && (v < BV_ST + BV_ACT);
    endfunction

    function automatic bit b_win(int k);
        int h = k % BH_TOT;
        int v = (k / BH_TOT) % BV_TOT;
        return b_act(k) && (h - BH_ST < BCOLS) && (v - BV_ST < BROWS);
    endfunction

    function automatic bit s_act(int k);
        int h = k % SH_TOT;
        int v = (k / SH_TOT) % SV_TOT;
        return (h >= SH_ST) && (h < SH_ST + SH_ACT) && (v >= SV_ST) && (v < SV_ST + SV_ACT);
    endfunction

    function automatic bit s_win(int k);
        int h = k % SH_TOT;
        int v = (k / SH_TOT) % SV_TOT;
        return s_act(k) && (h - SH_ST < SCOLS) && (v - SV_ST < SROWS);
    endfunction

    task automatic test_reset();
        b_reset = 1'b1; b_in_valid = 1'b1; b_in_pixel = 8'h5A;
        repeat (5) @(negedge clk);
        n_checks++; if (b_hs !== 1'b1) begin n_fail++; $display("FAIL reset_hs: got %b expected 1", b_hs); end
        n_checks++; if (b_vs !== 1'b1) begin n_fail++; $display("FAIL reset_vs: got %b expected 1", b_vs); end
        n_checks++; if (b_de !== 1'b0) begin n_fail++; $display("FAIL reset_de: got %b expected 0", b_de); end
        n_checks++; if ({b_r, b_g, b_b} !== 24'h0) begin n_fail++; $display("FAIL reset_rgb: got %h expected 000000", {b_r, b_g, b_b}); end
        n_checks++; if (b_fs !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %b expected 0", b_fs); end
        n_checks++; if (b_un !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b expected 0", b_un); end
        n_checks++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", b_in_ready); end
    endtask

    // Two full lines after release: HS shape, frame_start, no video yet.
    task automatic test_hsync();
        int hs_low = 0, vs_low = 0, fs_n = 0, de_n = 0, rdy_n = 0;
        int fall1 = -1, fall2 = -1;
        logic prev_hs = 1'b1;
        b_reset = 1'b0; bk = 0;
        for (int k = 1; k <= 2 * BH_TOT; k++) begin
            @(negedge clk); bk++;
            if (!b_hs) hs_low++;
            if (prev_hs && !b_hs) begin
                if (fall1 < 0) fall1 = k; else if (fall2 < 0) fall2 = k;
            end
            prev_hs = b_hs;
            if (!b_vs) vs_low++;
            if (b_fs) fs_n++;
            if (b_de) de_n++;
            if (b_in_ready) rdy_n++;
        end
        n_checks++; if (fall1 != 1) begin n_fail++; $display("FAIL hs_first_fall: got cycle %0d expected 1", fall1); end
        n_checks++; if (fall2 - fall1 != BH_TOT) begin n_fail++; $display("FAIL hs_period: got %0d expected %0d", fall2 - fall1, BH_TOT); end
        n_checks++; if (hs_low != 2 * BH_SYNC) begin n_fail++; $display("FAIL hs_low_cycles: got %0d expected %0d", hs_low, 2 * BH_SYNC); end
        n_checks++; if (vs_low != 2 * BH_TOT) begin n_fail++; $display("FAIL vs_low_lines01: got %0d expected %0d", vs_low, 2 * BH_TOT); end
        n_checks++; if (fs_n != 1) begin n_fail++; $display("FAIL frame_start_count: got %0d expected 1", fs_n); end
        n_checks++; if (de_n != 0) begin n_fail++; $display("FAIL de_in_vblank: got %0d expected 0", de_n); end
        n_checks++; if (rdy_n != 0) begin n_fail++; $display("FAIL ready_in_vblank: got %0d expected 0", rdy_n); end
    endtask

    // Run through line 27 (first image line) with in_valid held high and an incrementing source.
    task automatic test_image_line();
        int mism = 0, acc = 0, rdy_n = 0, de_n = 0, tail = 0, vs_low = 2 * BH_TOT, first_acc = -1;
        int h;
        bit exp_ready, xfer, exp_de, exp_hs, exp_vs;
        logic [7:0] exp_pix;
        while (bk < (BV_ST + 1) * BH_TOT) begin
            h         = bk % BH_TOT;
            exp_ready = b_win(bk);
            if (b_in_ready !== exp_ready) mism++;
            if (b_in_ready) rdy_n++;
            xfer    = exp_ready && b_in_valid;
            exp_pix = xfer ? b_in_pixel : 8'h00;
            exp_de  = b_act(bk);
            exp_hs  = (h >= BH_SYNC);
            exp_vs  = ((bk / BH_TOT) >= BV_SYNC);
            @(negedge clk); bk++;
            if (b_r !== exp_pix || b_g !== exp_pix || b_b !== exp_pix) mism++;
            if (b_de !== exp_de || b_hs !== exp_hs || b_vs !== exp_vs) mism++;
            if (!b_vs) vs_low++;
            if (b_de) de_n++;
            if (b_de && (h - BH_ST) >= BCOLS && b_r === 8'h00) tail++;
            if (xfer) begin
                if (first_acc < 0) first_acc = int'(b_r);
                acc++;
                b_in_pixel = b_in_pixel + 8'd1;
            end
        end
        n_checks++; if (mism != 0) begin n_fail++; $display("FAIL image_cycle_model: %0d mismatching cycles, expected 0", mism); end
        n_checks++; if (rdy_n != BCOLS) begin n_fail++; $display("FAIL image_ready_cycles: got %0d expected %0d", rdy_n, BCOLS); end
        n_checks++; if (acc != BCOLS) begin n_fail++; $display("FAIL image_accepted: got %0d expected %0d", acc, BCOLS); end
        n_checks++; if (first_acc != 8'h5A) begin n_fail++; $display("FAIL first_pixel_unconsumed: got %0h expected 5a", first_acc); end
        n_checks++; if (de_n != BH_ACT) begin n_fail++; $display("FAIL de_line27: got %0d expected %0d", de_n, BH_ACT); end
        n_checks++; if (tail != BH_ACT - BCOLS) begin n_fail++; $display("FAIL black_right_of_image: got %0d expected %0d", tail, BH_ACT - BCOLS); end
        n_checks++; if (vs_low != BV_SYNC * BH_TOT) begin n_fail++; $display("FAIL vs_low_cycles: got %0d expected %0d", vs_low, BV_SYNC * BH_TOT); end
        n_checks++; if (b_un !== 1'b0) begin n_fail++; $display("FAIL big_underrun: got %b expected 0", b_un); end
    endtask

    // Reduced raster, two frames; in_valid dropped for the 3rd image pixel of frame 1.
    task automatic test_underrun();
        int mism = 0, hs_low = 0, vs_low = 0, de_n = 0, fs_n = 0, fs1 = -1, fs2 = -1;
        int h, v;
        bit exp_ready, xfer, drop, un_m;
        logic [7:0] exp_pix;
        logic un_before = 1'bx, un_after = 1'bx;
        logic [7:0] pix_drop = 8'hxx, pix_next = 8'hxx;
        un_m = 1'b0;
        s_in_valid = 1'b1; s_in_pixel = 8'h10;
        s_reset = 1'b0; sk = 0;
        for (int k = 1; k <= 2 * SFRAME; k++) begin
            h = sk % SH_TOT; v = (sk / SH_TOT) % SV_TOT;
            drop = (sk == SV_ST * SH_TOT + SH_ST + 2);
            s_in_valid = !drop;
            if (drop) un_before = s_un;
            exp_ready = s_win(sk);
            if (s_in_ready !== exp_ready) mism++;
            xfer    = exp_ready && s_in_valid;
            exp_pix = xfer ? s_in_pixel : 8'h00;
            un_m    = un_m | (exp_ready && !s_in_valid);
            @(negedge clk); sk++;
            if (s_r !== exp_pix || s_g !== exp_pix || s_b !== exp_pix) mism++;
            if (s_hs !== (h >= SH_SYNC) || s_vs !== (v >= SV_SYNC)) mism++;
            if (s_de !== s_act(k - 1) || s_fs !== (h == 0 && v == 0) || s_un !== un_m) mism++;
            if (drop) begin pix_drop = s_r; un_after = s_un; end
            if (sk == SV_ST * SH_TOT + SH_ST + 4) pix_next = s_r;
            if (!s_hs) hs_low++;
            if (!s_vs) vs_low++;
            if (s_de) de_n++;
            if (s_fs) begin fs_n++; if (fs1 < 0) fs1 = k; else fs2 = k; end
            if (xfer) s_in_pixel = s_in_pixel + 8'd1;
        end
        s_in_valid = 1'b1;
        n_checks++; if (mism != 0) begin n_fail++; $display("FAIL small_cycle_model: %0d mismatching cycles, expected 0", mism); end
        n_checks++; if (un_before !== 1'b0) begin n_fail++; $display("FAIL underrun_before_drop: got %b expected 0", un_before); end
        n_checks++; if (pix_drop !== 8'h00) begin n_fail++; $display("FAIL starved_pixel: got %h expected 00", pix_drop); end
        n_checks++; if (un_after !== 1'b1) begin n_fail++; $display("FAIL underrun_set: got %b expected 1", un_after); end
        n_checks++; if (pix_next !== 8'h12) begin n_fail++; $display("FAIL pixel_after_starve: got %h expected 12", pix_next); end
        n_checks++; if (s_un !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky: got %b expected 1", s_un); end
        n_checks++; if (hs_low != 2 * SV_TOT * SH_SYNC) begin n_fail++; $display("FAIL small_hs_low: got %0d expected %0d", hs_low, 2 * SV_TOT * SH_SYNC); end
        n_checks++; if (vs_low != 2 * SV_SYNC * SH_TOT) begin n_fail++; $display("FAIL small_vs_low: got %0d expected %0d", vs_low, 2 * SV_SYNC * SH_TOT); end
        n_checks++; if (de_n != 2 * SH_ACT * SV_ACT) begin n_fail++; $display("FAIL small_de_count: got %0d expected %0d", de_n, 2 * SH_ACT * SV_ACT); end
        n_checks++; if (fs_n != 2 || fs2 - fs1 != SFRAME) begin n_fail++; $display("FAIL frame_start_period: got %0d pulses, period %0d, expected 2 and %0d", fs_n, fs2 - fs1, SFRAME); end
    endtask

    // One-cycle reset in the middle of an image pixel, then the restart must match power-up.
    task automatic test_midframe_reset();
        int mism = 0, h, v;
        bit exp_ready, xfer;
        logic [7:0] exp_pix;
        repeat (SV_ST * SH_TOT + SH_ST + 2) begin @(negedge clk); sk++; end
        s_reset = 1'b1;
        #1;
        n_checks++; if (s_in_ready !== 1'b0) begin n_fail++; $display("FAIL ready_during_reset: got %b expected 0", s_in_ready); end
        @(negedge clk);
        n_checks++; if (s_hs !== 1'b1 || s_vs !== 1'b1) begin n_fail++; $display("FAIL midreset_sync: got HS=%b VS=%b expected 1 1", s_hs, s_vs); end
        n_checks++; if (s_de !== 1'b0 || s_r !== 8'h00 || s_fs !== 1'b0) begin n_fail++; $display("FAIL midreset_video: got de=%b R=%h fs=%b expected 0 00 0", s_de, s_r, s_fs); end
        n_checks++; if (s_un !== 1'b0) begin n_fail++; $display("FAIL midreset_underrun: got %b expected 0", s_un); end
        s_reset = 1'b0; sk = 0;
        @(negedge clk); sk++;
        n_checks++; if (s_hs !== 1'b0 || s_vs !== 1'b0 || s_fs !== 1'b1) begin n_fail++; $display("FAIL restart_first: got HS=%b VS=%b fs=%b expected 0 0 1", s_hs, s_vs, s_fs); end
        while (sk < SFRAME + 1) begin
            h = sk % SH_TOT; v = (sk / SH_TOT) % SV_TOT;
            exp_ready = s_win(sk);
            if (s_in_ready !== exp_ready) mism++;
            xfer    = exp_ready && s_in_valid;
            exp_pix = xfer ? s_in_pixel : 8'h00;
            @(negedge clk); sk++;
            if (s_r !== exp_pix || s_hs !== (h >= SH_SYNC) || s_vs !== (v >= SV_SYNC)) mism++;
            if (s_de !== s_act(sk - 1) || s_fs !== (h == 0 && v == 0) || s_un !== 1'b0) mism++;
            if (xfer) s_in_pixel = s_in_pixel + 8'd1;
        end
        n_checks++; if (mism != 0) begin n_fail++; $display("FAIL restart_frame_model: %0d mismatching cycles, expected 0", mism); end
    endtask

    initial begin
        b_reset = 1'b1; b_in_valid = 1'b0; b_in_pixel = 8'h00;
        s_reset = 1'b1; s_in_valid = 1'b0; s_in_pixel = 8'h00;
        test_reset();
        test_hsync();
        test_image_line();
        test_underrun();
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
